// File: rtl/spi_target_pkg.sv
// Shared SPI definitions: default frame width, synchronizer depth and the
// responder state encoding.
package spi_target_pkg;

  localparam int unsigned SPI_DATA_W      = 16;
  localparam int unsigned SPI_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_target_if.sv
// SPI pad bundle between an initiator (master) and a responder (slave).
//   sclk    : serial clock, idles low
//   cs      : chip select, active low
//   mosi    : initiator -> responder data, MSB first
//   miso    : responder -> initiator data, MSB first
//   miso_oe : responder pad driver enable
interface spi_target_if;
  logic sclk;
  logic cs;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (output sclk, output cs, output mosi, input miso, input miso_oe);
  modport slave  (input sclk, input cs, input mosi, output miso, output miso_oe);
endinterface

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer with rise/fall pulse detection.
//   clk, rst_n : system clock, async active-low reset
//   i_d        : asynchronous input
//   o_q        : synchronized level (last stage)
//   o_rise     : one-cycle pulse on synchronized 0->1
//   o_fall     : one-cycle pulse on synchronized 1->0
module spi_sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_dly;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {STAGES{RST_VAL}};
      r_dly  <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_dly  <= r_sync[STAGES-1];
    end
  end

  assign o_q    = r_sync[STAGES-1];
  assign o_rise = r_sync[STAGES-1] & ~r_dly;
  assign o_fall = ~r_sync[STAGES-1] & r_dly;

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 responder running in the system clock domain.
//   clk, rst_n : system clock (>= 4x sclk), async active-low reset
//   spi        : SPI pads (slave modport): sclk, cs, mosi in; miso, miso_oe out
//   tx_data    : word shifted out, captured at each frame start
//   rx_data    : last complete received word
//   rx_valid   : one-cycle pulse when rx_data updates
//   frame_err  : one-cycle pulse when a frame ends with bit count != DATA_W
//   busy       : high while a frame is being shifted
module spi_target
  import spi_target_pkg::*;
#(
  parameter int unsigned DATA_W      = SPI_DATA_W,
  parameter int unsigned SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_target_if.slave       spi,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned          CNT_W    = $clog2(DATA_W + 2);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]     CNT_FULL = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0]     CNT_SAT  = CNT_W'(DATA_W + 1);
  localparam int unsigned          WARM_W   = $clog2(SYNC_STAGES + 2);
  localparam logic [WARM_W-1:0]    WARM_ONE = WARM_W'(1);
  localparam logic [WARM_W-1:0]    WARM_END = WARM_W'(SYNC_STAGES + 1);

  spi_state_e r_state, w_state_nxt;

  logic w_sclk_q, w_sclk_rise, w_sclk_fall;
  logic w_cs_q, w_cs_rise, w_cs_fall;
  logic w_mosi;
  logic w_start;

  logic [SYNC_STAGES-1:0] r_mosi_sync;
  // Holds the bits still to be sent after the one currently on miso.
  logic [DATA_W-2:0]      r_shift_tx;
  logic [DATA_W-1:0]      r_shift_rx;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic                   r_miso;
  logic [DATA_W-1:0]      r_rx_data;
  logic                   r_rx_valid;
  logic                   r_rx_pend;
  logic [WARM_W-1:0]      r_warm;
  logic                   r_armed;
  logic                   r_start_pend;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    (spi.sclk),
    .o_q    (w_sclk_q),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    (spi.cs),
    .o_q    (w_cs_q),
    .o_rise (w_cs_rise),
    .o_fall (w_cs_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_mosi_sync <= '0;
    else        r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi.mosi};
  end
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (r_armed && (w_cs_fall || r_start_pend)) begin
          w_state_nxt = SHIFT;
          w_start     = 1'b1;
        end
      end
      SHIFT: begin
        if (w_cs_rise) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift_tx   <= '0;
      r_shift_rx   <= '0;
      r_bit_cnt    <= '0;
      r_miso       <= 1'b0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_rx_pend    <= 1'b0;
      r_warm       <= '0;
      r_armed      <= 1'b0;
      r_start_pend <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (r_rx_pend) begin
        r_rx_data  <= r_shift_rx;
        r_rx_valid <= 1'b1;
        r_rx_pend  <= 1'b0;
      end

      // The synchronizers come out of reset showing cs high, so a cs that is
      // already low would look like a falling edge. Only accept frames once a
      // real idle bus (cs high, sclk low) has been seen after reset.
      if (r_warm != WARM_END) r_warm <= r_warm + WARM_ONE;
      if (r_warm == WARM_END && w_cs_q && !w_sclk_q) r_armed <= 1'b1;

      // A cs fall arriving during DONE is replayed in the following IDLE cycle.
      r_start_pend <= (r_state == DONE) && w_cs_fall && r_armed;

      if (w_start) begin
        r_shift_tx <= tx_data[DATA_W-2:0];
        r_miso     <= tx_data[DATA_W-1];
        r_bit_cnt  <= '0;
      end else if (r_state == SHIFT) begin
        if (w_sclk_rise) begin
          r_shift_rx <= {r_shift_rx[DATA_W-2:0], w_mosi};
          if (r_bit_cnt != CNT_SAT) r_bit_cnt <= r_bit_cnt + CNT_ONE;
          if (r_bit_cnt == CNT_LAST) r_rx_pend <= 1'b1;
        end
        if (w_sclk_fall) begin
          if (r_bit_cnt < CNT_FULL) begin
            r_miso     <= r_shift_tx[DATA_W-2];
            r_shift_tx <= {r_shift_tx[DATA_W-3:0], 1'b0};
          end else begin
            r_miso <= 1'b0;
          end
        end
        if (w_cs_rise) r_miso <= 1'b0;
      end
    end
  end

  assign spi.miso    = r_miso;
  assign spi.miso_oe = (r_state == SHIFT);
  assign busy        = (r_state == SHIFT);
  assign frame_err   = (r_state == DONE) && (r_bit_cnt != CNT_FULL);
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;

endmodule

// File: tb/tb_spi_target.sv
module tb_spi_target;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] tx_data;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        frame_err;
  logic        busy;

  spi_target_if spi_bus ();

  spi_target #(.DATA_W(16), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi       (spi_bus),
    .tx_data   (tx_data),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Event monitor: counts output pulses and records delivered words.
  int unsigned rxv_cnt = 0;
  int unsigned fe_cnt  = 0;
  logic [15:0] rx_q[$];

  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      rxv_cnt++;
      rx_q.push_back(rx_data);
    end
    if (frame_err === 1'b1) fe_cnt++;
  end

  // Reference model: last complete word the responder should hold.
  logic [15:0] m_rx;

  // Expected miso stream: tx word MSB first, zeros past bit 16.
  function automatic logic [31:0] model_miso(input logic [15:0] tx, input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[31-i] = (i < 16) ? tx[15-i] : 1'b0;
    return r;
  endfunction

  task automatic model_frame(input logic [31:0] bits, input int n,
                             output int unsigned e_rxv, output int unsigned e_fe);
    e_rxv = (n >= 16) ? 1 : 0;
    e_fe  = (n != 16) ? 1 : 0;
    if (n >= 16) m_rx = bits[31:16];
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One mode-0 bit at clk/8: data set while sclk low, miso sampled just before rise.
  task automatic spi_bit(input logic b, output logic m, output logic oe);
    spi_bus.mosi = b;
    wclk(4);
    m  = spi_bus.miso;
    oe = spi_bus.miso_oe;
    spi_bus.sclk = 1'b1;
    wclk(4);
    spi_bus.sclk = 1'b0;
  endtask

  task automatic spi_frame(input logic [31:0] bits, input int n, input int chg_at,
                           input logic [15:0] tx_new,
                           output logic [31:0] mcap, output logic oe_all);
    logic m, oe;
    mcap   = '0;
    oe_all = 1'b1;
    spi_bus.cs = 1'b0;
    wclk(4);
    for (int i = 0; i < n; i++) begin
      if (i == chg_at) tx_data = tx_new;
      spi_bit(bits[31-i], m, oe);
      mcap[31-i] = m;
      oe_all &= oe;
    end
    wclk(4);
    spi_bus.cs = 1'b1;
  endtask

  task automatic test_reset();
    int unsigned rv0, fe0;
    rst_n = 1'b0;
    spi_bus.cs = 1'b1; spi_bus.sclk = 1'b0; spi_bus.mosi = 1'b0;
    tx_data = 16'h0;
    m_rx = 16'h0;
    wclk(3);
    n_total++; if (spi_bus.miso !== 1'b0) $display("FAIL reset_miso: got %b want 0", spi_bus.miso); else n_pass++;
    n_total++; if (spi_bus.miso_oe !== 1'b0) $display("FAIL reset_miso_oe: got %b want 0", spi_bus.miso_oe); else n_pass++;
    n_total++; if (rx_data !== 16'h0) $display("FAIL reset_rx_data: got %h want 0000", rx_data); else n_pass++;
    n_total++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b want 0", rx_valid); else n_pass++;
    n_total++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b want 0", frame_err); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    rv0 = rxv_cnt; fe0 = fe_cnt;
    rst_n = 1'b1;
    wclk(12);
    n_total++; if (busy !== 1'b0) $display("FAIL post_reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (rxv_cnt - rv0 != 0 || fe_cnt - fe0 != 0)
      $display("FAIL post_reset_pulses: got rxv=%0d fe=%0d want 0/0", rxv_cnt - rv0, fe_cnt - fe0); else n_pass++;
  endtask

  task automatic test_nominal();
    int unsigned rv0, fe0, e_rxv, e_fe;
    logic [31:0] mcap, bits;
    logic oe_all;
    tx_data = 16'hA5C3;
    bits = {16'h1234, 16'h0};
    rv0 = rxv_cnt; fe0 = fe_cnt;
    model_frame(bits, 16, e_rxv, e_fe);
    spi_frame(bits, 16, -1, 16'h0, mcap, oe_all);
    wclk(8);
    n_total++; if (mcap !== model_miso(16'hA5C3, 16)) $display("FAIL nom_miso: got %h want %h", mcap, model_miso(16'hA5C3, 16)); else n_pass++;
    n_total++; if (rx_data !== m_rx) $display("FAIL nom_rx_data: got %h want %h", rx_data, m_rx); else n_pass++;
    n_total++; if (rxv_cnt - rv0 != e_rxv) $display("FAIL nom_rx_valid: got %0d want %0d", rxv_cnt - rv0, e_rxv); else n_pass++;
    n_total++; if (fe_cnt - fe0 != e_fe) $display("FAIL nom_frame_err: got %0d want %0d", fe_cnt - fe0, e_fe); else n_pass++;
    n_total++; if (oe_all !== 1'b1) $display("FAIL nom_oe_during: got %b want 1", oe_all); else n_pass++;
    n_total++; if (spi_bus.miso_oe !== 1'b0) $display("FAIL nom_oe_after: got %b want 0", spi_bus.miso_oe); else n_pass++;
  endtask

  task automatic test_short();
    int unsigned rv0, fe0, e_rxv, e_fe;
    logic [31:0] mcap, bits;
    logic [15:0] tx;
    logic oe_all;
    tx = 16'($urandom);
    tx_data = tx;
    bits = $urandom;
    rv0 = rxv_cnt; fe0 = fe_cnt;
    model_frame(bits, 9, e_rxv, e_fe);
    spi_frame(bits, 9, -1, 16'h0, mcap, oe_all);
    wclk(8);
    n_total++; if (fe_cnt - fe0 != e_fe) $display("FAIL short_frame_err: got %0d want %0d", fe_cnt - fe0, e_fe); else n_pass++;
    n_total++; if (rxv_cnt - rv0 != e_rxv) $display("FAIL short_rx_valid: got %0d want %0d", rxv_cnt - rv0, e_rxv); else n_pass++;
    n_total++; if (rx_data !== m_rx) $display("FAIL short_rx_data: got %h want %h", rx_data, m_rx); else n_pass++;
    n_total++; if (mcap !== model_miso(tx, 9)) $display("FAIL short_miso: got %h want %h", mcap, model_miso(tx, 9)); else n_pass++;
  endtask

  task automatic test_long();
    int unsigned rv0, fe0, e_rxv, e_fe;
    logic [31:0] mcap, bits;
    logic [15:0] tx;
    logic oe_all;
    tx = 16'($urandom);
    tx_data = tx;
    bits = {16'hBEEF, 4'($urandom), 12'h0};
    rv0 = rxv_cnt; fe0 = fe_cnt;
    model_frame(bits, 20, e_rxv, e_fe);
    spi_frame(bits, 20, -1, 16'h0, mcap, oe_all);
    wclk(8);
    n_total++; if (rx_data !== m_rx) $display("FAIL long_rx_data: got %h want %h", rx_data, m_rx); else n_pass++;
    n_total++; if (rxv_cnt - rv0 != e_rxv) $display("FAIL long_rx_valid: got %0d want %0d", rxv_cnt - rv0, e_rxv); else n_pass++;
    n_total++; if (fe_cnt - fe0 != e_fe) $display("FAIL long_frame_err: got %0d want %0d", fe_cnt - fe0, e_fe); else n_pass++;
    n_total++; if (mcap[31:16] !== tx) $display("FAIL long_miso_word: got %h want %h", mcap[31:16], tx); else n_pass++;
    n_total++; if (mcap[15:12] !== 4'h0) $display("FAIL long_miso_tail: got %h want 0", mcap[15:12]); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int unsigned rv0, fe0, q0, e1, f1, e2, f2;
    logic [31:0] m1, m2, b1, b2;
    logic [15:0] tx1, tx2, tx3, got1, got2;
    logic oe1, oe2;
    tx1 = 16'($urandom); tx2 = 16'($urandom); tx3 = 16'($urandom);
    b1 = {16'($urandom), 16'h0};
    b2 = {16'($urandom), 16'h0};
    rv0 = rxv_cnt; fe0 = fe_cnt; q0 = rx_q.size();
    tx_data = tx1;
    model_frame(b1, 16, e1, f1);
    spi_frame(b1, 16, 5, tx2, m1, oe1);
    wclk(2);
    model_frame(b2, 16, e2, f2);
    spi_frame(b2, 16, 7, tx3, m2, oe2);
    wclk(8);
    got1 = (rx_q.size() > q0)     ? rx_q[q0]     : 16'hxxxx;
    got2 = (rx_q.size() > q0 + 1) ? rx_q[q0 + 1] : 16'hxxxx;
    n_total++; if (m1 !== model_miso(tx1, 16)) $display("FAIL b2b_miso1: got %h want %h", m1, model_miso(tx1, 16)); else n_pass++;
    n_total++; if (m2 !== model_miso(tx2, 16)) $display("FAIL b2b_miso2: got %h want %h", m2, model_miso(tx2, 16)); else n_pass++;
    n_total++; if (rxv_cnt - rv0 != e1 + e2) $display("FAIL b2b_rx_valid: got %0d want %0d", rxv_cnt - rv0, e1 + e2); else n_pass++;
    n_total++; if (got1 !== b1[31:16]) $display("FAIL b2b_word1: got %h want %h", got1, b1[31:16]); else n_pass++;
    n_total++; if (got2 !== b2[31:16]) $display("FAIL b2b_word2: got %h want %h", got2, b2[31:16]); else n_pass++;
    n_total++; if (fe_cnt - fe0 != f1 + f2) $display("FAIL b2b_frame_err: got %0d want %0d", fe_cnt - fe0, f1 + f2); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    int unsigned rv0, fe0, e_rxv, e_fe;
    logic [31:0] mcap, bits;
    logic [15:0] tx;
    logic m, oe, oe_all, busy_seen;
    tx_data = 16'($urandom);
    spi_bus.cs = 1'b0;
    wclk(4);
    for (int i = 0; i < 7; i++) spi_bit(1'($urandom), m, oe);
    rst_n = 1'b0;
    m_rx = 16'h0;
    wclk(2);
    n_total++; if (busy !== 1'b0 || spi_bus.miso_oe !== 1'b0 || spi_bus.miso !== 1'b0)
      $display("FAIL midrst_outputs: got busy=%b oe=%b miso=%b want 0/0/0", busy, spi_bus.miso_oe, spi_bus.miso); else n_pass++;
    rst_n = 1'b1;
    rv0 = rxv_cnt; fe0 = fe_cnt;
    busy_seen = 1'b0;
    for (int i = 0; i < 9; i++) begin
      spi_bit(1'($urandom), m, oe);
      busy_seen |= busy;
    end
    wclk(4);
    spi_bus.cs = 1'b1;
    wclk(8);
    n_total++; if (busy_seen !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy_seen); else n_pass++;
    n_total++; if (rxv_cnt - rv0 != 0) $display("FAIL midrst_rx_valid: got %0d want 0", rxv_cnt - rv0); else n_pass++;
    n_total++; if (fe_cnt - fe0 != 0) $display("FAIL midrst_frame_err: got %0d want 0", fe_cnt - fe0); else n_pass++;
    n_total++; if (rx_data !== m_rx) $display("FAIL midrst_rx_data: got %h want %h", rx_data, m_rx); else n_pass++;
    tx = 16'($urandom);
    tx_data = tx;
    bits = {16'h0F0F, 16'h0};
    rv0 = rxv_cnt; fe0 = fe_cnt;
    model_frame(bits, 16, e_rxv, e_fe);
    spi_frame(bits, 16, -1, 16'h0, mcap, oe_all);
    wclk(8);
    n_total++; if (rx_data !== m_rx) $display("FAIL after_rst_rx_data: got %h want %h", rx_data, m_rx); else n_pass++;
    n_total++; if (rxv_cnt - rv0 != e_rxv) $display("FAIL after_rst_rx_valid: got %0d want %0d", rxv_cnt - rv0, e_rxv); else n_pass++;
    n_total++; if (fe_cnt - fe0 != e_fe) $display("FAIL after_rst_frame_err: got %0d want %0d", fe_cnt - fe0, e_fe); else n_pass++;
    n_total++; if (mcap !== model_miso(tx, 16)) $display("FAIL after_rst_miso: got %h want %h", mcap, model_miso(tx, 16)); else n_pass++;
  endtask

  task automatic test_random_frames();
    int unsigned rv0, fe0, e_rxv, e_fe;
    int n;
    logic [31:0] mcap, bits;
    logic [15:0] tx;
    logic oe_all;
    for (int k = 0; k < 6; k++) begin
      n = int'($urandom_range(20, 12));
      tx = 16'($urandom);
      tx_data = tx;
      bits = $urandom;
      rv0 = rxv_cnt; fe0 = fe_cnt;
      model_frame(bits, n, e_rxv, e_fe);
      spi_frame(bits, n, -1, 16'h0, mcap, oe_all);
      wclk(8);
      n_total++; if (mcap !== model_miso(tx, n)) $display("FAIL rnd%0d_miso n=%0d: got %h want %h", k, n, mcap, model_miso(tx, n)); else n_pass++;
      n_total++; if (rx_data !== m_rx) $display("FAIL rnd%0d_rx_data n=%0d: got %h want %h", k, n, rx_data, m_rx); else n_pass++;
      n_total++; if (rxv_cnt - rv0 != e_rxv) $display("FAIL rnd%0d_rx_valid n=%0d: got %0d want %0d", k, n, rxv_cnt - rv0, e_rxv); else n_pass++;
      n_total++; if (fe_cnt - fe0 != e_fe) $display("FAIL rnd%0d_frame_err n=%0d: got %0d want %0d", k, n, fe_cnt - fe0, e_fe); else n_pass++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_nominal();
    test_short();
    test_long();
    test_back_to_back();
    test_reset_midframe();
    test_random_frames();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
